// File: rtl/axis_eth_tx_arbiter_pkg.sv
// Shared definitions for the Ethernet TX stream arbiter.
// Contents:
//   arbstate_t        arbiter state encoding; ARB_ABORT is used only in the watchdog build
//   MAX_TX_ARB_PORTS  largest supported number of frame sources
//   TX_ARB_CNT_WIDTH  width of the drop/abort/idle counters
//   sat_inc()         saturating increment for the status counters
package EthTxArbPkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FWD,
    ARB_DROP,
    ARB_ABORT
  } arbstate_t;

  localparam int MAX_TX_ARB_PORTS = 8;
  localparam int TX_ARB_CNT_WIDTH = 16;

  // Status counters stick at all-ones instead of wrapping.
  function automatic logic [TX_ARB_CNT_WIDTH-1:0] sat_inc(input logic [TX_ARB_CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_eth_tx_arbiter_if.sv
// AXI-Stream bundle with LANES parallel 32-bit lanes (lane i at tdata[32*i +: 32],
// tkeep[4*i +: 4]). The arbiter uses a LANES=NUM_PORTS bundle on the source side
// and a LANES=1 bundle on the MAC side.
//
// Handshake: a beat transfers on a cycle where tvalid and tready are both 1.
// tdata/tkeep/tlast/tuser are meaningful only while tvalid is 1.
//
// Modports:
//   master  drives tvalid/tdata/tkeep/tlast/tuser, receives tready
//   slave   receives tvalid/tdata/tkeep/tlast/tuser, drives tready
interface axis_eth_tx_arbiter_if #(
  parameter int LANES = 1
) ();

  logic [LANES-1:0]    tvalid;
  logic [LANES-1:0]    tready;
  logic [32*LANES-1:0] tdata;
  logic [4*LANES-1:0]  tkeep;
  logic [LANES-1:0]    tlast;
  logic [LANES-1:0]    tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/axis_eth_tx_arbiter_round_robin_picker.sv
// Combinational round-robin selector.
// Ports:
//   req    in   N          request vector
//   last   in   clog2(N)   index granted most recently; search starts just above it
//   valid  out  1          at least one request present
//   sel    out  clog2(N)   first requester found scanning last+1, last+2, ... modulo N
module round_robin_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 valid,
  output logic [$clog2(N)-1:0] sel
);

  localparam int SW = $clog2(N);

  always_comb begin
    valid = 1'b0;
    sel   = '0;
    // k = N wraps back to 'last' itself, so a lone requester is regranted.
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[(int'(last) + k) % N]) begin
        valid = 1'b1;
        sel   = SW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/axis_eth_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one 32-bit AXI-Stream MAC TX port
// between NUM_PORTS frame sources. A granted source owns the MAC until its tlast
// beat. Frames granted while the link is down are accepted and discarded.
//
// Optional build macro: ETH_TX_ARB_WATCHDOG_EN
//   Defined: a granted source idle for TIMEOUT_CYCLES consecutive cycles gets its
//   frame terminated with an error beat (tlast=1, tuser=1) and the rest of the
//   source frame is discarded. Undefined: a stalled source keeps the grant.
//
// Ports:
//   aclk, areset_n  clock and synchronous active-low reset
//   link_up         MAC link state (already synchronous to aclk), sampled at grant
//   s_axis          source bundle (slave modport, NUM_PORTS lanes)
//   m_axis          MAC bundle (master modport, 1 lane)
//   grant_id        current owner, valid while busy
//   busy            arbiter not idle
//   drop_count      frames discarded for link down (saturating)
//   abort_count     watchdog aborts (saturating, 0 without watchdog)
//   state_dbg       current FSM state
module axis_eth_tx_arbiter
  import EthTxArbPkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic                        link_up,
  axis_eth_tx_arbiter_if.slave        s_axis,
  axis_eth_tx_arbiter_if.master       m_axis,
  output logic [2:0]                  grant_id,
  output logic                        busy,
  output logic [TX_ARB_CNT_WIDTH-1:0] drop_count,
  output logic [TX_ARB_CNT_WIDTH-1:0] abort_count,
  output arbstate_t                   state_dbg
);

  localparam int IDW = $clog2(NUM_PORTS);

  arbstate_t      state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] pick_sel;
  logic           pick_valid;
  logic           g_hs;
  logic           g_last;

  round_robin_picker #(.N(NUM_PORTS)) u_picker (
    .req   (s_axis.tvalid),
    .last  (rr_ptr),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  assign g_hs      = s_axis.tvalid[grant] & s_axis.tready[grant];
  assign g_last    = s_axis.tlast[grant];
  assign grant_id  = 3'(grant);
  assign busy      = (state != ARB_IDLE);
  assign state_dbg = state;

  // MAC side is a zero-latency passthrough of the owner while forwarding; all
  // other states present an idle (all-zero) bus unless an abort beat is due.
  always_comb begin
    m_axis.tvalid = '0;
    m_axis.tdata  = '0;
    m_axis.tkeep  = '0;
    m_axis.tlast  = '0;
    m_axis.tuser  = '0;
    s_axis.tready = '0;
    case (state)
      ARB_FWD: begin
        m_axis.tvalid        = s_axis.tvalid[grant];
        m_axis.tdata         = s_axis.tdata[32*grant +: 32];
        m_axis.tkeep         = s_axis.tkeep[4*grant +: 4];
        m_axis.tlast         = s_axis.tlast[grant];
        m_axis.tuser         = s_axis.tuser[grant];
        s_axis.tready[grant] = m_axis.tready[0];
      end
      ARB_DROP: begin
        s_axis.tready[grant] = 1'b1;
      end
`ifdef ETH_TX_ARB_WATCHDOG_EN
      ARB_ABORT: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = 1'b1;
        m_axis.tuser  = 1'b1;
        m_axis.tkeep  = 4'hF;
      end
`endif
      default: ;
    endcase
  end

`ifdef ETH_TX_ARB_WATCHDOG_EN
  logic [TX_ARB_CNT_WIDTH-1:0] idle_cnt;
  logic [TX_ARB_CNT_WIDTH-1:0] abort_cnt_q;
  // Set when DROP is finishing off an aborted frame, which is not a link drop.
  logic                        drop_silent;

  assign abort_count = abort_cnt_q;
`else
  assign abort_count = '0;
`endif

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      rr_ptr     <= IDW'(NUM_PORTS - 1);
      drop_count <= '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      idle_cnt    <= '0;
      abort_cnt_q <= '0;
      drop_silent <= 1'b0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant  <= pick_sel;
            rr_ptr <= pick_sel;
            state  <= link_up ? ARB_FWD : ARB_DROP;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            idle_cnt    <= '0;
            drop_silent <= 1'b0;
`endif
          end
        end
        ARB_FWD: begin
          if (g_hs && g_last) begin
            state <= ARB_IDLE;
          end
`ifdef ETH_TX_ARB_WATCHDOG_EN
          // Only source-side silence counts; MAC back-pressure keeps tvalid high.
          else if (s_axis.tvalid[grant]) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TX_ARB_CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            state <= ARB_ABORT;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        ARB_DROP: begin
          if (g_hs && g_last) begin
            state <= ARB_IDLE;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            if (!drop_silent) drop_count <= sat_inc(drop_count);
`else
            drop_count <= sat_inc(drop_count);
`endif
          end
        end
`ifdef ETH_TX_ARB_WATCHDOG_EN
        ARB_ABORT: begin
          if (m_axis.tready[0]) begin
            abort_cnt_q <= sat_inc(abort_cnt_q);
            drop_silent <= 1'b1;
            state       <= ARB_DROP;
          end
        end
`endif
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_eth_tx_arbiter.sv
module tb_axis_eth_tx_arbiter;
  import EthTxArbPkg::*;

  localparam int N = 4;
`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif
  // Beat packing: {tuser, tlast, tkeep[3:0], tdata[31:0]}
  localparam int W = 38;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        link_up = 1'b1;
  logic [2:0]  grant_id;
  logic        busy;
  logic [15:0] drop_count;
  logic [15:0] abort_count;
  arbstate_t   state_dbg;

  axis_eth_tx_arbiter_if #(.LANES(N)) s_if ();
  axis_eth_tx_arbiter_if #(.LANES(1)) m_if ();

  axis_eth_tx_arbiter #(.NUM_PORTS(N), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .link_up     (link_up),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .grant_id    (grant_id),
    .busy        (busy),
    .drop_count  (drop_count),
    .abort_count (abort_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #4 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [W-1:0] src_q[N][$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int got_cyc[$];
  int exp_grants[$];
  int grant_log[$];
  logic [N-1:0] hs = '0;
  int beats_in_frame[N];
  bit gaps_en = 0, rdy_rand = 0, prev_busy = 0, saw_mvalid = 0;
  int model_rr = N - 1;
  int model_drops = 0;
  int model_aborts = 0;
  int stall_port = -1, stall_beat = 0, stall_len = 0;

  // ---------------- driver tasks ----------------
  task automatic add_frame(input int p, input int len);
    logic [W-1:0] b;
    for (int i = 0; i < len; i++) begin
      b[31:0]  = $urandom;
      b[35:32] = (i == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
      b[36]    = (i == len - 1);
      b[37]    = (i == len - 1) && ($urandom_range(0, 3) == 0);
      src_q[p].push_back(b);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < N; p++) s += src_q[p].size();
    return s;
  endfunction

  task automatic clear_logs();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    grant_log.delete(); exp_grants.delete(); saw_mvalid = 0;
  endtask

  // Reference model: whole frames go out in round-robin order among sources that
  // have a frame waiting; when the link is down nothing reaches the MAC.
  task automatic build_expect(input bit link);
    logic [W-1:0] mq[N][$];
    logic [W-1:0] b;
    int p;
    bit found;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    found = 1;
    while (found) begin
      found = 0;
      p = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && mq[(model_rr + k) % N].size() > 0) begin
          found = 1;
          p = (model_rr + k) % N;
        end
      end
      if (found) begin
        exp_grants.push_back(p);
        model_rr = p;
        if (!link) model_drops++;
        do begin
          b = mq[p].pop_front();
          if (link) exp_q.push_back(b);
        end while (!b[36]);
      end
    end
  endtask

  // One clock: sample at negedge, then drive the next cycle's inputs after posedge.
  task automatic step();
    logic [W-1:0] head;
    logic [N-1:0] v;
    @(negedge aclk);
    hs = s_if.tvalid & s_if.tready;
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      got_q.push_back({m_if.tuser[0], m_if.tlast[0], m_if.tkeep, m_if.tdata});
      got_cyc.push_back(cyc);
    end
    if (m_if.tvalid[0]) saw_mvalid = 1;
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    prev_busy = busy;
    @(posedge aclk);
    #1;
    cyc++;
    v = '0;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        head = src_q[p].pop_front();
        beats_in_frame[p] = head[36] ? 0 : beats_in_frame[p] + 1;
      end
      if (src_q[p].size() > 0) begin
        head = src_q[p][0];
        v[p] = 1'b1;
        if (gaps_en && beats_in_frame[p] > 0 && $urandom_range(0, 3) == 0) v[p] = 1'b0;
        if (p == stall_port && beats_in_frame[p] == stall_beat && stall_len > 0) begin
          v[p] = 1'b0;
          stall_len--;
        end
        s_if.tdata[32*p +: 32] = head[31:0];
        s_if.tkeep[4*p +: 4]   = head[35:32];
        s_if.tlast[p]          = head[36];
        s_if.tuser[p]          = head[37];
      end else begin
        s_if.tdata[32*p +: 32] = '0;
        s_if.tkeep[4*p +: 4]   = '0;
        s_if.tlast[p]          = 1'b0;
        s_if.tuser[p]          = 1'b0;
      end
    end
    s_if.tvalid = v;
    m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_drain(input int budget, output bit ok);
    int n = 0;
    do begin
      step();
      n++;
    end while (n < budget && (busy || pending() > 0));
    ok = !(busy || pending() > 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset_n = 1'b0;
    s_if.tvalid = '1; s_if.tdata = '1; s_if.tkeep = '1; s_if.tlast = '1; s_if.tuser = '1;
    m_if.tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", m_if.tvalid); end
    checks++; if (m_if.tdata !== 32'h0) begin errors++; $display("FAIL reset_m_tdata: got %h expected 0", m_if.tdata); end
    checks++; if ({m_if.tlast, m_if.tuser, m_if.tkeep} !== 6'h0) begin errors++; $display("FAIL reset_m_ctrl: got %h expected 0", {m_if.tlast, m_if.tuser, m_if.tkeep}); end
    checks++; if (s_if.tready !== 4'h0) begin errors++; $display("FAIL reset_s_tready: got %b expected 0000", s_if.tready); end
    checks++; if (grant_id !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_grant_busy: got %0d/%b expected 0/0", grant_id, busy); end
    checks++; if (drop_count !== 16'd0 || abort_count !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", drop_count, abort_count); end
    checks++; if (state_dbg !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ARB_IDLE); end
    @(posedge aclk); #1;
    areset_n = 1'b1;
    s_if.tvalid = '0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = '0; s_if.tuser = '0;
    model_rr = N - 1; model_drops = 0; model_aborts = 0;
  endtask

  task automatic test_round_robin();
    bit ok;
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) add_frame(p, $urandom_range(1, 6));
    build_expect(1'b1);
    run_drain(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_drain: got pending %0d expected 0", pending()); end
    checks++; if (grant_log.size() != 8) begin errors++; $display("FAIL rr_grant_count: got %0d expected 8", grant_log.size()); end
    for (int i = 0; i < grant_log.size() && i < 8; i++) begin
      checks++; if (grant_log[i] != i % N) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", i, grant_log[i], i % N); end
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_beat_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_two_ports();
    bit ok;
    clear_logs();
    add_frame(0, 4);
    add_frame(2, 4);
    build_expect(1'b1);
    run_drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_drain: got pending %0d expected 0", pending()); end
    checks++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
      errors++; $display("FAIL two_grants: got count %0d expected order 0,2", grant_log.size());
    end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL two_beats: got %0d expected 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_beat_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (got_cyc.size() < 8 || got_cyc[3] - got_cyc[0] != 3) begin errors++; $display("FAIL two_no_latency: frame beats not back-to-back"); end
    checks++; if (got_cyc.size() < 8 || got_cyc[4] - got_cyc[3] != 2) begin errors++; $display("FAIL two_bubble: gap between frames is not one cycle"); end
  endtask

  task automatic test_single_requester();
    bit ok;
    clear_logs();
    add_frame(3, 3);
    add_frame(3, 3);
    build_expect(1'b1);
    run_drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: got pending %0d expected 0", pending()); end
    checks++; if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 3) begin
      errors++; $display("FAIL single_grants: got count %0d expected order 3,3", grant_log.size());
    end
    checks++; if (got_cyc.size() != 6 || got_cyc[3] - got_cyc[2] != 2) begin errors++; $display("FAIL single_bubble: got %0d beats, gap not one cycle", got_cyc.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_link_down();
    int n = 0;
    int bad = 0;
    int busy_cycles = 0;
    clear_logs();
    link_up = 1'b0;
    add_frame(1, 3);
    build_expect(1'b0);
    while ((busy || pending() > 0) && n < 200) begin
      step();
      n++;
      if (busy) begin
        busy_cycles++;
        if (s_if.tready !== 4'b0010) bad++;
      end
    end
    link_up = 1'b1;
    checks++; if (pending() != 0) begin errors++; $display("FAIL drop_drain: got pending %0d expected 0", pending()); end
    checks++; if (bad != 0 || busy_cycles != 3) begin errors++; $display("FAIL drop_tready: got %0d bad of %0d busy cycles expected 0 of 3", bad, busy_cycles); end
    checks++; if (saw_mvalid) begin errors++; $display("FAIL drop_m_tvalid: got 1 expected never"); end
    checks++; if (drop_count !== 16'(model_drops)) begin errors++; $display("FAIL drop_count: got %0d expected %0d", drop_count, model_drops); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL drop_beats: got %0d expected 0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    gaps_en = 1; rdy_rand = 1;
    add_frame(0, 64);
    build_expect(1'b1);
    run_drain(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got pending %0d expected 0", pending()); end
    checks++; if (got_q.size() != 64) begin errors++; $display("FAIL bp_beats: got %0d expected 64", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_mix();
    bit ok;
    clear_logs();
    gaps_en = 1; rdy_rand = 1;
    for (int i = 0; i < 16; i++) add_frame($urandom_range(0, N - 1), $urandom_range(1, 8));
    build_expect(1'b1);
    run_drain(4000, ok);
    gaps_en = 0; rdy_rand = 0;
    checks++; if (!ok) begin errors++; $display("FAIL mix_drain: got pending %0d expected 0", pending()); end
    checks++; if (grant_log.size() != exp_grants.size()) begin errors++; $display("FAIL mix_grant_count: got %0d expected %0d", grant_log.size(), exp_grants.size()); end
    for (int i = 0; i < grant_log.size() && i < exp_grants.size(); i++) begin
      checks++; if (grant_log[i] != exp_grants[i]) begin errors++; $display("FAIL mix_grant_%0d: got %0d expected %0d", i, grant_log[i], exp_grants[i]); end
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mix_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mix_beat_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef ETH_TX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok;
    clear_logs();
    add_frame(3, 6);
    exp_q.push_back(src_q[3][0]);
    exp_q.push_back(src_q[3][1]);
    exp_q.push_back({1'b1, 1'b1, 4'hF, 32'h0});
    model_rr = 3;
    model_aborts++;
    stall_port = 3; stall_beat = 2; stall_len = 20;
    run_drain(300, ok);
    stall_port = -1;
    checks++; if (!ok) begin errors++; $display("FAIL wd_drain: got pending %0d expected 0", pending()); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL wd_beats: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wd_beat_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (got_cyc.size() != 3 || got_cyc[2] - got_cyc[1] != TB_TIMEOUT + 1) begin errors++; $display("FAIL wd_timing: abort beat not after %0d idle cycles", TB_TIMEOUT); end
    checks++; if (abort_count !== 16'(model_aborts)) begin errors++; $display("FAIL wd_abort_count: got %0d expected %0d", abort_count, model_aborts); end
    checks++; if (drop_count !== 16'(model_drops)) begin errors++; $display("FAIL wd_drop_count: got %0d expected %0d", drop_count, model_drops); end
    clear_logs();
    add_frame(0, 2);
    build_expect(1'b1);
    run_drain(100, ok);
    checks++; if (!ok || got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL wd_next_frame: got %0d beats expected 2 intact", got_q.size());
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    bit ok;
    clear_logs();
    add_frame(1, 10);
    repeat (5) step();
    areset_n = 1'b0;
    @(posedge aclk); #1;
    areset_n = 1'b1;
    for (int p = 0; p < N; p++) begin src_q[p].delete(); beats_in_frame[p] = 0; end
    s_if.tvalid = '0;
    hs = '0; prev_busy = 0;
    model_rr = N - 1; model_drops = 0; model_aborts = 0;
    @(negedge aclk);
    checks++; if (m_if.tvalid !== 1'b0 || m_if.tdata !== 32'h0) begin errors++; $display("FAIL rst_mid_m: got valid %b data %h expected 0/0", m_if.tvalid, m_if.tdata); end
    checks++; if (s_if.tready !== 4'h0 || busy !== 1'b0 || grant_id !== 3'd0) begin errors++; $display("FAIL rst_mid_ctrl: got tready %b busy %b grant %0d expected 0", s_if.tready, busy, grant_id); end
    checks++; if (drop_count !== 16'd0 || abort_count !== 16'd0) begin errors++; $display("FAIL rst_mid_counters: got %0d/%0d expected 0/0", drop_count, abort_count); end
    clear_logs();
    add_frame(2, 2);
    add_frame(0, 2);
    add_frame(3, 2);
    build_expect(1'b1);
    run_drain(200, ok);
    checks++; if (!ok || grant_log.size() != 3 || grant_log[0] != 0) begin errors++; $display("FAIL rst_mid_first_grant: got %0d grants, first not port 0", grant_log.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_beat_%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int p = 0; p < N; p++) beats_in_frame[p] = 0;
    s_if.tvalid = '0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = '0; s_if.tuser = '0;
    m_if.tready = 1'b1;
    test_reset();
    test_round_robin();
    test_two_ports();
    test_single_requester();
    test_link_down();
    test_backpressure();
    test_random_mix();
`ifdef ETH_TX_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
